eeprom_arbiter: RTL and testbench
=================================

# eeprom_arbiter

Two-port arbiter and sequencer for the serial EEPROM read/write engine. It accepts byte read and write requests from two independent requesters (A and B) and grants them round-robin. It drives the engine's WR/RD/address/data strobes for one transaction at a time and returns read data and a completion or timeout status. It sits between the system-side masters and the EEPROM engine, and enforces a programmable idle gap after every transaction to cover the EEPROM internal write time.

## Interface
- TIMEOUT_CYC, 4095: maximum BUSY cycles waiting for engine ACK before the transaction is aborted; legal 1..65535.
- GAP_CYC, 16: idle cycles inserted after every transaction before the next arbitration; legal 0..65535.

- CLK  in  1  single clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- a_req / b_req  in  1  request level; held until the matching gnt is seen.
- a_we / b_we  in  1  1 = write byte, 0 = read byte.
- a_addr / b_addr  in  11  byte address.
- a_wdata / b_wdata  in  8  write data; ignored for reads.
- a_gnt / b_gnt  out  1  one-cycle pulse: request accepted and its fields captured.
- a_done / b_done  out  1  one-cycle pulse: transaction finished; rdata/err valid this cycle.
- rdata  out  8  read data; valid with done, and holds until the next done.
- err  out  1  valid with done; 1 = ACK timeout.
- busy  out  1  high from grant until the end of GAP.
- eep_wr / eep_rd  out  1  engine write/read strobes; level-held until ACK or timeout.
- eep_addr  out  11  engine address.
- eep_dout  out  8  data driven to the engine's bidirectional data bus.
- eep_doe  out  1  output enable for eep_dout; high only during a write.
- eep_din  in  8  data returned from the engine's data bus.
- eep_ack  in  1  engine end-of-transaction acknowledge (pulse).

## Operation
- States: IDLE, BUSY, DONE, GAP.
- IDLE: if any req is high, pick a winner.
  - Only one requester high: it wins.
  - Both high: the side holding the priority pointer wins.
  - On the edge that leaves IDLE: capture winner's we/addr/wdata into eep_*, pulse the winner's gnt, flip the pointer to the other side, go to BUSY.
- BUSY:
  - eep_wr = we, eep_rd = ~we, eep_doe = we.
  - 16-bit timeout counter starts at 0 and increments each BUSY cycle.
  - eep_ack = 1: capture eep_din into rdata if a read, clear err, go to DONE.
  - No ack and counter == TIMEOUT_CYC-1: set err = 1, leave rdata unchanged, go to DONE.
- DONE (1 cycle):
  - eep_wr, eep_rd and eep_doe are low.
  - The granted side's done pulses.
  - Go to GAP, or to IDLE if GAP_CYC = 0.
- GAP: count GAP_CYC cycles with eep_* strobes low, then go to IDLE.
- eep_addr and eep_dout hold their last value outside BUSY.
- Requester fields are sampled only on the grant edge; the requester may drop req or change fields during the gnt cycle.
- A req still high when IDLE is re-entered is a new request.

## Timing
- Reset values:
  - state IDLE, pointer = A.
  - a_gnt, b_gnt, a_done, b_done, err, busy, eep_wr, eep_rd, eep_doe = 0.
  - rdata, eep_addr, eep_dout = 0.
  - counters = 0.
- Reset asserted mid-transaction drops all strobes immediately (asynchronously). No done is issued for the aborted transaction.
- Request latency: req high in IDLE at cycle k → gnt, busy, and eep_wr/eep_rd high in cycle k+1.
- Completion latency: eep_ack high in cycle m → strobes low and done high in cycle m+1.
- Minimum transaction length: grant, 1 BUSY cycle, DONE, then GAP_CYC cycles.
- Back-to-back spacing from one done to the next gnt: GAP_CYC+1 cycles.
- Timeout with no ack: strobes are high for exactly TIMEOUT_CYC cycles, then done with err = 1.
- eep_ack in the same cycle the counter hits terminal count: ack wins, err = 0.
- eep_ack outside BUSY is ignored.
- Both req rising in the same IDLE cycle: pointer decides.
- The pointer flips only on a grant.

## Test plan
- Single write: reset, then a_req=1, a_we=1, addr=0x155, wdata=0xA5.
  - Required: a_gnt in the next cycle.
  - Required: eep_wr=1, eep_doe=1, eep_addr=0x155, eep_dout=0xA5 until eep_ack, injected 20 cycles later.
  - Required: a_done one cycle after ack with err=0, then 16 GAP cycles with busy=1.
- Read: b_req read at addr 0x7FF, engine returns eep_din=0x3C with ack.
  - Required: b_done with rdata=0x3C, err=0, and eep_rd is the only strobe.
- Contention: a_req and b_req rise together after reset.
  - Required: A granted first; B granted GAP_CYC+1 cycles after a_done.
  - Repeat with both held: grants alternate A, B, A, B.
- Timeout: TIMEOUT_CYC=8 and no ack.
  - Required: eep_wr high for exactly 8 cycles, then done with err=1 and rdata unchanged.
  - Variant: ack in the 8th cycle gives err=0.
- Reset mid-BUSY: assert RESET during a write.
  - Required: all outputs at reset values asynchronously, no done pulse.
  - Required: a new request after reset is granted normally with the pointer at A.
- GAP_CYC=0: two queued requests.
  - Required: second gnt in the cycle immediately after the first done.

Source files
------------

// File: rtl/eeprom_arbiter.sv
// Round-robin two-port arbiter/sequencer for the serial EEPROM engine.
// One transaction at a time: grant, BUSY until ack or timeout, DONE pulse, idle GAP.
module eeprom_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 4095,
  parameter int unsigned GAP_CYC     = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [10:0] a_addr,
  input  logic [7:0]  a_wdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [10:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        a_gnt,
  output logic        b_gnt,
  output logic        a_done,
  output logic        b_done,
  output logic [7:0]  rdata,
  output logic        err,
  output logic        busy,
  output logic        eep_wr,
  output logic        eep_rd,
  output logic [10:0] eep_addr,
  output logic [7:0]  eep_dout,
  output logic        eep_doe,
  input  logic [7:0]  eep_din,
  input  logic        eep_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, GAP} state_t;

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;    // 0: A holds priority, 1: B holds priority
  logic        side_q, side_d;  // owner of the current transaction (1 = B)
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        arb;
  logic        pick_b;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    side_d  = side_q;
    gnt_d   = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    arb     = 1'b0;
    pick_b  = b_req && (!a_req || ptr_q);

    case (state_q)
      IDLE: arb = 1'b1;
      BUSY: begin
        if (eep_ack) begin
          if (!we_q) rdata_d = eep_din;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        cnt_d = '0;
        if (GAP_CYC == 0) arb = 1'b1;
        else state_d = GAP;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          arb   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The edge that returns to IDLE already arbitrates, so a waiting
    // requester is granted in the first cycle IDLE would have occupied.
    if (arb) begin
      state_d = IDLE;
      if (a_req || b_req) begin
        state_d = BUSY;
        side_d  = pick_b;
        ptr_d   = ~pick_b;
        gnt_d   = 1'b1;
        we_d    = pick_b ? b_we : a_we;
        addr_d  = pick_b ? b_addr : a_addr;
        dout_d  = pick_b ? b_wdata : a_wdata;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      side_q  <= 1'b0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      side_q  <= side_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode from the state register so reset drops them at once.
  assign a_gnt    = gnt_q & ~side_q;
  assign b_gnt    = gnt_q & side_q;
  assign a_done   = (state_q == DONE) & ~side_q;
  assign b_done   = (state_q == DONE) & side_q;
  assign busy     = (state_q != IDLE);
  assign eep_wr   = (state_q == BUSY) & we_q;
  assign eep_rd   = (state_q == BUSY) & ~we_q;
  assign eep_doe  = (state_q == BUSY) & we_q;
  assign eep_addr = addr_q;
  assign eep_dout = dout_q;
  assign rdata    = rdata_q;
  assign err      = err_q;

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Directed bench for eeprom_arbiter: instance 0 uses TIMEOUT 4095 / GAP 16,
// instance 1 uses TIMEOUT 8 / GAP 0.
module tb_eeprom_arbiter;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic       a_req [2], a_we [2], b_req [2], b_we [2], eep_ack [2];
  logic [10:0] a_addr [2], b_addr [2], eep_addr [2];
  logic [7:0]  a_wdata [2], b_wdata [2], eep_din [2], rdata [2], eep_dout [2];
  logic       a_gnt [2], b_gnt [2], a_done [2], b_done [2], err [2], busy [2];
  logic       eep_wr [2], eep_rd [2], eep_doe [2];
  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    eeprom_arbiter #(
      .TIMEOUT_CYC(gi == 0 ? 4095 : 8),
      .GAP_CYC    (gi == 0 ? 16 : 0)
    ) u_dut (
      .CLK(CLK), .RESET(RESET),
      .a_req(a_req[gi]), .a_we(a_we[gi]), .a_addr(a_addr[gi]), .a_wdata(a_wdata[gi]),
      .b_req(b_req[gi]), .b_we(b_we[gi]), .b_addr(b_addr[gi]), .b_wdata(b_wdata[gi]),
      .a_gnt(a_gnt[gi]), .b_gnt(b_gnt[gi]), .a_done(a_done[gi]), .b_done(b_done[gi]),
      .rdata(rdata[gi]), .err(err[gi]), .busy(busy[gi]),
      .eep_wr(eep_wr[gi]), .eep_rd(eep_rd[gi]), .eep_addr(eep_addr[gi]),
      .eep_dout(eep_dout[gi]), .eep_doe(eep_doe[gi]),
      .eep_din(eep_din[gi]), .eep_ack(eep_ack[gi])
    );
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [35:0] outs(int d);
    return {a_gnt[d], b_gnt[d], a_done[d], b_done[d], err[d], busy[d],
            eep_wr[d], eep_rd[d], eep_doe[d], rdata[d], eep_addr[d], eep_dout[d]};
  endfunction

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      a_req[d] = 1'b0; a_we[d] = 1'b0; a_addr[d] = '0; a_wdata[d] = '0;
      b_req[d] = 1'b0; b_we[d] = 1'b0; b_addr[d] = '0; b_wdata[d] = '0;
      eep_din[d] = '0; eep_ack[d] = 1'b0;
    end
  endtask

  task automatic wait_idle(int d);
    int n = 0;
    while (busy[d] && n < 100) begin tick(); n++; end
    checks++;
    if (busy[d] !== 1'b0) begin
      errors++; $display("FAIL wait_idle dut%0d: busy=%b after %0d cycles, want 0", d, busy[d], n);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (outs(d) !== 36'd0) begin
        errors++; $display("FAIL reset_values dut%0d: got %h want 0", d, outs(d));
      end
    end
    RESET = 1'b0;
    tick();
    checks++;
    if (busy[0] !== 1'b0 || a_gnt[0] !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b a_gnt=%b want 0 0", busy[0], a_gnt[0]);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_write();
    logic ok;
    a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 11'h155; a_wdata[0] = 8'hA5;
    tick();
    checks++;
    if ({a_gnt[0], b_gnt[0], busy[0], eep_wr[0], eep_rd[0], eep_doe[0]} !== 6'b101101
        || eep_addr[0] !== 11'h155 || eep_dout[0] !== 8'hA5) begin
      errors++; $display("FAIL write_grant: gnt a/b=%b%b busy=%b wr/rd/oe=%b%b%b addr=%h dout=%h want 10 1 101 155 a5",
        a_gnt[0], b_gnt[0], busy[0], eep_wr[0], eep_rd[0], eep_doe[0], eep_addr[0], eep_dout[0]);
    end
    a_req[0] = 1'b0; a_addr[0] = 11'h000; a_wdata[0] = 8'h00;
    ok = 1'b1;
    repeat (19) begin
      tick();
      if (eep_wr[0] !== 1'b1 || eep_doe[0] !== 1'b1 || eep_addr[0] !== 11'h155 ||
          eep_dout[0] !== 8'hA5 || a_gnt[0] !== 1'b0 || a_done[0] !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL write_hold: strobes/fields not held during BUSY (ok=%b want 1)", ok);
    end
    eep_ack[0] = 1'b1;
    tick();
    eep_ack[0] = 1'b0;
    checks++;
    if ({a_done[0], b_done[0], err[0], eep_wr[0], eep_doe[0], busy[0]} !== 6'b100001 || rdata[0] !== 8'h00) begin
      errors++; $display("FAIL write_done: done a/b=%b%b err=%b wr=%b oe=%b busy=%b rdata=%h want 10 0 0 0 1 00",
        a_done[0], b_done[0], err[0], eep_wr[0], eep_doe[0], busy[0], rdata[0]);
    end
    ok = 1'b1;
    repeat (16) begin
      tick();
      if (busy[0] !== 1'b1 || eep_wr[0] !== 1'b0 || eep_rd[0] !== 1'b0 || a_done[0] !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL write_gap: busy/strobes wrong during 16 GAP cycles (ok=%b want 1)", ok);
    end
    tick();
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++; $display("FAIL write_gap_end: busy=%b want 0", busy[0]);
    end
    $display("write: a addr=155 data=a5 complete");
  endtask

  task automatic test_read();
    eep_ack[0] = 1'b1;
    tick();
    eep_ack[0] = 1'b0;
    checks++;
    if ({a_done[0], b_done[0], busy[0]} !== 3'b000) begin
      errors++; $display("FAIL idle_ack_ignored: done a/b=%b%b busy=%b want 000", a_done[0], b_done[0], busy[0]);
    end
    b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 11'h7FF; b_wdata[0] = 8'hEE;
    tick();
    b_req[0] = 1'b0;
    checks++;
    if ({a_gnt[0], b_gnt[0], eep_wr[0], eep_rd[0], eep_doe[0]} !== 5'b01010 || eep_addr[0] !== 11'h7FF) begin
      errors++; $display("FAIL read_grant: gnt a/b=%b%b wr/rd/oe=%b%b%b addr=%h want 01 010 7ff",
        a_gnt[0], b_gnt[0], eep_wr[0], eep_rd[0], eep_doe[0], eep_addr[0]);
    end
    eep_din[0] = 8'h3C; eep_ack[0] = 1'b1;
    tick();
    eep_ack[0] = 1'b0; eep_din[0] = 8'h55;
    checks++;
    if ({a_done[0], b_done[0], err[0]} !== 3'b010 || rdata[0] !== 8'h3C) begin
      errors++; $display("FAIL read_done: done a/b=%b%b err=%b rdata=%h want 01 0 3c", a_done[0], b_done[0], err[0], rdata[0]);
    end
    wait_idle(0);
    checks++;
    if (rdata[0] !== 8'h3C) begin
      errors++; $display("FAIL read_hold: rdata=%h want 3c", rdata[0]);
    end
    $display("read: b addr=7ff rdata=%h", rdata[0]);
  endtask

  task automatic test_contention();
    int n;
    RESET = 1'b1; tick(); RESET = 1'b0; tick();
    a_req[0] = 1'b1; a_we[0] = 1'b1; b_req[0] = 1'b1; b_we[0] = 1'b1;
    tick();
    a_req[0] = 1'b0;
    checks++;
    if ({a_gnt[0], b_gnt[0]} !== 2'b10) begin
      errors++; $display("FAIL contention_first: gnt a/b=%b%b want 10", a_gnt[0], b_gnt[0]);
    end
    eep_ack[0] = 1'b1; tick(); eep_ack[0] = 1'b0;
    n = 0;
    while (b_gnt[0] !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n !== 17) begin
      errors++; $display("FAIL contention_spacing: done-to-b_gnt=%0d cycles want 17", n);
    end
    $display("contention: A first, B after %0d cycles", n);
  endtask

  task automatic test_back_to_back();
    logic exp_b;
    int n;
    a_req[0] = 1'b1;
    eep_ack[0] = 1'b1; tick(); eep_ack[0] = 1'b0;
    exp_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (a_gnt[0] !== 1'b1 && b_gnt[0] !== 1'b1 && n < 40) begin tick(); n++; end
      checks++;
      if ({a_gnt[0], b_gnt[0]} !== {~exp_b, exp_b}) begin
        errors++; $display("FAIL alternate_%0d: gnt a/b=%b%b want %b%b", i, a_gnt[0], b_gnt[0], ~exp_b, exp_b);
      end
      $display("back_to_back: grant %0d to %s", i, b_gnt[0] ? "B" : "A");
      exp_b = ~exp_b;
      eep_ack[0] = 1'b1; tick(); eep_ack[0] = 1'b0;
    end
    a_req[0] = 1'b0; b_req[0] = 1'b0;
    wait_idle(0);
  endtask

  task automatic test_timeout();
    int n;
    b_req[1] = 1'b1; b_we[1] = 1'b0; b_addr[1] = 11'h010;
    tick();
    b_req[1] = 1'b0;
    eep_din[1] = 8'h96; eep_ack[1] = 1'b1; tick(); eep_ack[1] = 1'b0; eep_din[1] = 8'h00;
    tick();
    a_req[1] = 1'b1; a_we[1] = 1'b1; a_addr[1] = 11'h123; a_wdata[1] = 8'h5A;
    tick();
    a_req[1] = 1'b0;
    n = 0;
    while (eep_wr[1] === 1'b1 && n < 20) begin n++; tick(); end
    checks++;
    if (n !== 8) begin
      errors++; $display("FAIL timeout_len: eep_wr high %0d cycles want 8", n);
    end
    checks++;
    if ({a_done[1], err[1]} !== 2'b11 || rdata[1] !== 8'h96) begin
      errors++; $display("FAIL timeout_done: a_done=%b err=%b rdata=%h want 1 1 96", a_done[1], err[1], rdata[1]);
    end
    tick();
    a_req[1] = 1'b1;
    tick();
    a_req[1] = 1'b0;
    repeat (7) tick();
    checks++;
    if (eep_wr[1] !== 1'b1) begin
      errors++; $display("FAIL ack_last_busy: eep_wr=%b in 8th cycle want 1", eep_wr[1]);
    end
    eep_ack[1] = 1'b1; tick(); eep_ack[1] = 1'b0;
    checks++;
    if ({a_done[1], err[1]} !== 2'b10) begin
      errors++; $display("FAIL ack_at_terminal: a_done=%b err=%b want 1 0", a_done[1], err[1]);
    end
    $display("timeout: 8-cycle abort and terminal-count ack checked");
  endtask

  task automatic test_reset_mid_busy();
    logic seen;
    a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 11'h2AA; a_wdata[0] = 8'h11;
    tick();
    a_req[0] = 1'b0;
    repeat (3) tick();
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (outs(0) !== 36'd0) begin
      errors++; $display("FAIL reset_async: got %h want 0", outs(0));
    end
    seen = 1'b0;
    repeat (2) begin tick(); seen = seen | a_done[0] | b_done[0]; end
    RESET = 1'b0;
    repeat (5) begin tick(); seen = seen | a_done[0] | b_done[0]; end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_no_done: done seen=%b want 0", seen);
    end
    a_req[0] = 1'b1; b_req[0] = 1'b1;
    tick();
    a_req[0] = 1'b0; b_req[0] = 1'b0;
    checks++;
    if ({a_gnt[0], b_gnt[0]} !== 2'b10 || eep_addr[0] !== 11'h2AA) begin
      errors++; $display("FAIL reset_regrant: gnt a/b=%b%b addr=%h want 10 2aa", a_gnt[0], b_gnt[0], eep_addr[0]);
    end
    eep_ack[0] = 1'b1; tick(); eep_ack[0] = 1'b0;
    wait_idle(0);
    $display("reset_mid_busy: aborted cleanly, A regranted");
  endtask

  task automatic test_gap0();
    a_req[1] = 1'b1; b_req[1] = 1'b1; a_we[1] = 1'b0; b_we[1] = 1'b0;
    tick();
    a_req[1] = 1'b0;
    checks++;
    if ({a_gnt[1], b_gnt[1]} !== 2'b10) begin
      errors++; $display("FAIL gap0_first: gnt a/b=%b%b want 10", a_gnt[1], b_gnt[1]);
    end
    eep_ack[1] = 1'b1; tick(); eep_ack[1] = 1'b0;
    checks++;
    if (a_done[1] !== 1'b1) begin
      errors++; $display("FAIL gap0_done: a_done=%b want 1", a_done[1]);
    end
    tick();
    b_req[1] = 1'b0;
    checks++;
    if ({a_gnt[1], b_gnt[1]} !== 2'b01) begin
      errors++; $display("FAIL gap0_second: gnt a/b=%b%b want 01", a_gnt[1], b_gnt[1]);
    end
    eep_ack[1] = 1'b1; tick(); eep_ack[1] = 1'b0;
    wait_idle(1);
    $display("gap0: second grant right after first done");
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_back_to_back();
    test_timeout();
    test_reset_mid_busy();
    test_gap0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
